// File: rtl/dqn_target_net.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | dqn_target_net : 2-32-32-3 leaky-ReLU FP32 target Q-network, serial MAC,  |
// |                  reports max Q. Optional TARGET_NET_READBACK_EN readback.  |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module dqn_target_net #(
   parameter int          DATA_WIDTH                    = 32,
   parameter int          LAYER_WIDTH                   = 2,
   parameter int          NUMBER_OF_INPUT_NODE          = 2,
   parameter int          NUMBER_OF_HIDDEN_NODE_LAYER_1 = 32,
   parameter int          NUMBER_OF_HIDDEN_NODE_LAYER_2 = 32,
   parameter int          NUMBER_OF_OUTPUT_NODE         = 3,
   parameter logic [31:0] ALPHA                         = 32'h3DCCCCCD,
   localparam int c_WADDR_W = $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_2*(NUMBER_OF_HIDDEN_NODE_LAYER_1+1)),
   localparam int c_DAW     = $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_data_valid,
   input  logic [c_DAW-1:0]       i_data_addr,
   input  logic [DATA_WIDTH-1:0]  i_data,
   input  logic                   i_weight_valid,
   input  logic                   i_rw_weight_select,
   input  logic [LAYER_WIDTH-1:0] i_weight_layer,
   input  logic [c_WADDR_W-1:0]   i_weight_addr,
   input  logic [DATA_WIDTH-1:0]  i_weight,
   output logic                   o_weight_valid,
   output logic [LAYER_WIDTH-1:0] o_weight_layer,
   output logic [c_WADDR_W-1:0]   o_weight_addr,
   output logic [DATA_WIDTH-1:0]  o_weight,
   output logic                   o_q_max_valid,
   output logic [DATA_WIDTH-1:0]  o_q_max
);

   localparam int c_NIN     = NUMBER_OF_INPUT_NODE;
   localparam int c_N1      = NUMBER_OF_HIDDEN_NODE_LAYER_1;
   localparam int c_N2      = NUMBER_OF_HIDDEN_NODE_LAYER_2;
   localparam int c_NOUT    = NUMBER_OF_OUTPUT_NODE;
   localparam int c_L1_SIZE = c_N1*(c_NIN+1);
   localparam int c_L2_SIZE = c_N2*(c_N1+1);
   localparam int c_L3_SIZE = c_NOUT*(c_N2+1);
   localparam int c_A1W     = $clog2(c_L1_SIZE);
   localparam int c_A2W     = $clog2(c_L2_SIZE);
   localparam int c_A3W     = $clog2(c_L3_SIZE);
   localparam int c_XW      = (c_NIN > 1) ? $clog2(c_NIN) : 1;
   localparam int c_HW      = $clog2(c_N1);
   localparam int c_H2W     = $clog2(c_N2);
   localparam int c_QW      = $clog2(c_NOUT);
   localparam int c_NW      = (c_N1 > c_N2) ? $clog2(c_N1) : $clog2(c_N2);
   localparam int c_KW      = (c_N1 > c_N2) ? $clog2(c_N1+1) : $clog2(c_N2+1);
   localparam logic [31:0] c_QNAN = 32'h7FC00000;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0, S_L1 = 3'd1, S_L2 = 3'd2, S_OUT = 3'd3, S_MAX = 3'd4, S_DONE = 3'd5
   } state_t;

   // FP32 multiply, round-to-nearest-even, denormals flushed to zero
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic               s, rnd;
      logic [47:0]        p;
      logic [23:0]        sig;
      logic [24:0]        r;
      logic signed [9:0]  e;
      logic [31:0]        res;
      s = a[31] ^ b[31];
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
         res = c_QNAN;
      else if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)
         res = (a[30:23] == 8'h00 || b[30:23] == 8'h00) ? c_QNAN : {s, 8'hFF, 23'b0};
      else if (a[30:23] == 8'h00 || b[30:23] == 8'h00)
         res = {s, 31'b0};
      else begin
         p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
         e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
         if (p[47]) begin
            sig = p[47:24];
            rnd = p[23] & ((|p[22:0]) | sig[0]);
            e   = e + 10'sd1;
         end else begin
            sig = p[46:23];
            rnd = p[22] & ((|p[21:0]) | sig[0]);
         end
         r = {1'b0, sig} + {24'b0, rnd};
         if (r[24]) begin
            r = r >> 1;
            e = e + 10'sd1;
         end
         if (e >= 10'sd255)     res = {s, 8'hFF, 23'b0};
         else if (e <= 10'sd0)  res = {s, 31'b0};
         else                   res = {s, e[7:0], r[22:0]};
      end
      return res;
   endfunction

   // FP32 add, 3 guard bits (guard/round/sticky), round-to-nearest-even, FTZ
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic [31:0]        x, y, res;
      logic [7:0]         d;
      logic [49:0]        wide;
      logic [26:0]        mx, my, n;
      logic [27:0]        s;
      logic [4:0]         lz;
      logic [24:0]        r;
      logic               rnd;
      logic signed [9:0]  e;
      res = '0;
      if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0))
         res = c_QNAN;
      else if (a[30:23] == 8'hFF && b[30:23] == 8'hFF)
         res = (a[31] == b[31]) ? a : c_QNAN;
      else if (a[30:23] == 8'hFF)                        res = a;
      else if (b[30:23] == 8'hFF)                        res = b;
      else if (a[30:23] == 8'h00 && b[30:23] == 8'h00)  res = {a[31] & b[31], 31'b0};
      else if (a[30:23] == 8'h00)                        res = b;
      else if (b[30:23] == 8'h00)                        res = a;
      else begin
         if (a[30:0] >= b[30:0]) begin x = a; y = b; end
         else                    begin x = b; y = a; end
         d  = x[30:23] - y[30:23];
         mx = {1'b1, x[22:0], 3'b000};
         if (d > 8'd26) my = 27'd1;
         else begin
            wide = {1'b1, y[22:0], 26'b0} >> d;
            my   = {wide[49:24], |wide[23:0]};
         end
         e = $signed({2'b00, x[30:23]});
         if (x[31] == y[31]) begin
            s = {1'b0, mx} + {1'b0, my};
            if (s[27]) begin
               n = {s[27:2], s[1] | s[0]};
               e = e + 10'sd1;
            end else n = s[26:0];
         end else begin
            s  = {1'b0, mx} - {1'b0, my};
            n  = s[26:0];
            lz = '0;
            for (int i = 0; i < 27; i++)
               if (n[i]) lz = 5'(26 - i);
            n = n << lz;
            e = e - $signed({5'b00000, lz});
         end
         if (n == 27'd0) res = 32'h0;
         else begin
            rnd = n[2] & (n[1] | n[0] | n[3]);
            r   = {1'b0, n[26:3]} + {24'b0, rnd};
            if (r[24]) begin
               r = r >> 1;
               e = e + 10'sd1;
            end
            if (e >= 10'sd255)     res = {x[31], 8'hFF, 23'b0};
            else if (e <= 10'sd0)  res = {x[31], 31'b0};
            else                   res = {x[31], e[7:0], r[22:0]};
         end
      end
      return res;
   endfunction

   // Signed compare for the max scan: sign first, then magnitude
   function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
      if (a[31] != b[31]) return !a[31];
      else if (!a[31])    return a[30:0] > b[30:0];
      else                return a[30:0] < b[30:0];
   endfunction

   logic [31:0] r_w1 [c_L1_SIZE];
   logic [31:0] r_w2 [c_L2_SIZE];
   logic [31:0] r_w3 [c_L3_SIZE];
   logic [31:0] r_x  [c_NIN];
   logic [31:0] r_h1 [c_N1];
   logic [31:0] r_h2 [c_N2];
   logic [31:0] r_q  [c_NOUT];

   state_t               r_state;
   logic [c_KW-1:0]      r_k;
   logic [c_NW-1:0]      r_node;
   logic [c_WADDR_W-1:0] r_base;
   logic [31:0]          r_acc, r_best;

   logic                 w_idle, w_data_wr, w_in_range, w_wr_en, w_wb;
   logic [c_KW-1:0]      w_fan_in;
   logic [c_NW-1:0]      w_last_node;
   state_t               w_next;
   logic [c_WADDR_W-1:0] w_w_addr, w_b_addr;
   logic [31:0]          w_weight, w_bias, w_x, w_sum, w_act;

   assign w_idle    = (r_state == S_IDLE);
   assign w_data_wr = w_idle && i_data_valid && (i_data_addr < c_DAW'(c_NIN));

   always_comb begin
      w_in_range = 1'b0;
      case (i_weight_layer)
         2'b01:   w_in_range = (i_weight_addr < c_WADDR_W'(c_L1_SIZE));
         2'b10:   w_in_range = (i_weight_addr < c_WADDR_W'(c_L2_SIZE));
         2'b11:   w_in_range = (i_weight_addr < c_WADDR_W'(c_L3_SIZE));
         default: w_in_range = 1'b0;
      endcase
   end

   assign w_wr_en = w_idle && i_weight_valid && !i_rw_weight_select && w_in_range;

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         case (i_weight_layer)
            2'b01:   r_w1[i_weight_addr[c_A1W-1:0]] <= i_weight;
            2'b10:   r_w2[i_weight_addr[c_A2W-1:0]] <= i_weight;
            2'b11:   r_w3[i_weight_addr[c_A3W-1:0]] <= i_weight;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_fan_in    = c_KW'(c_NIN);
      w_last_node = c_NW'(c_N1 - 1);
      w_next      = S_L2;
      case (r_state)
         S_L2: begin
            w_fan_in    = c_KW'(c_N1);
            w_last_node = c_NW'(c_N2 - 1);
            w_next      = S_OUT;
         end
         S_OUT: begin
            w_fan_in    = c_KW'(c_N2);
            w_last_node = c_NW'(c_NOUT - 1);
            w_next      = S_MAX;
         end
         default: ;
      endcase
   end

   // Node words sit at base..base+fan_in-1, bias at base+fan_in
   assign w_w_addr = r_base + c_WADDR_W'(r_k);
   assign w_b_addr = r_base + c_WADDR_W'(w_fan_in);

   always_comb begin
      w_weight = '0;
      w_bias   = '0;
      w_x      = '0;
      case (r_state)
         S_L1: begin
            w_weight = r_w1[w_w_addr[c_A1W-1:0]];
            w_bias   = r_w1[w_b_addr[c_A1W-1:0]];
            w_x      = r_x[r_k[c_XW-1:0]];
         end
         S_L2: begin
            w_weight = r_w2[w_w_addr[c_A2W-1:0]];
            w_bias   = r_w2[w_b_addr[c_A2W-1:0]];
            w_x      = r_h1[r_k[c_HW-1:0]];
         end
         S_OUT: begin
            w_weight = r_w3[w_w_addr[c_A3W-1:0]];
            w_bias   = r_w3[w_b_addr[c_A3W-1:0]];
            w_x      = r_h2[r_k[c_H2W-1:0]];
         end
         default: ;
      endcase
   end

   assign w_sum = fp_add((r_k == '0) ? w_bias : r_acc, fp_mul(w_weight, w_x));
   assign w_act = (r_state != S_OUT && r_acc[31]) ? fp_mul(ALPHA, r_acc) : r_acc;
   assign w_wb  = (r_state == S_L1 || r_state == S_L2 || r_state == S_OUT) && (r_k == w_fan_in);

   always_ff @(posedge clk) begin
      if (w_wb) begin
         case (r_state)
            S_L1:    r_h1[r_node[c_HW-1:0]]  <= w_act;
            S_L2:    r_h2[r_node[c_H2W-1:0]] <= w_act;
            S_OUT:   r_q[r_node[c_QW-1:0]]   <= w_act;
            default: ;
         endcase
      end
   end

`ifdef TARGET_NET_READBACK_EN
   logic        w_rd_en;
   logic [31:0] w_rd_data;

   assign w_rd_en = w_idle && i_weight_valid && i_rw_weight_select && w_in_range;

   always_comb begin
      w_rd_data = '0;
      case (i_weight_layer)
         2'b01:   w_rd_data = r_w1[i_weight_addr[c_A1W-1:0]];
         2'b10:   w_rd_data = r_w2[i_weight_addr[c_A2W-1:0]];
         2'b11:   w_rd_data = r_w3[i_weight_addr[c_A3W-1:0]];
         default: w_rd_data = '0;
      endcase
   end
`else
   assign o_weight_valid = 1'b0;
   assign o_weight_layer = '0;
   assign o_weight_addr  = '0;
   assign o_weight       = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_k           <= '0;
         r_node        <= '0;
         r_base        <= '0;
         r_acc         <= '0;
         r_best        <= '0;
         for (int i = 0; i < c_NIN; i++) r_x[i] <= '0;
         o_q_max_valid <= 1'b0;
         o_q_max       <= '0;
`ifdef TARGET_NET_READBACK_EN
         o_weight_valid <= 1'b0;
         o_weight_layer <= '0;
         o_weight_addr  <= '0;
         o_weight       <= '0;
`endif
      end else begin
         o_q_max_valid <= 1'b0;
`ifdef TARGET_NET_READBACK_EN
         o_weight_valid <= w_rd_en;
         if (w_rd_en) begin
            o_weight_layer <= i_weight_layer;
            o_weight_addr  <= i_weight_addr;
            o_weight       <= w_rd_data;
         end
`endif
         case (r_state)
            S_IDLE: begin
               if (w_data_wr) r_x[i_data_addr[c_XW-1:0]] <= i_data;
               if (w_data_wr && i_data_addr == c_DAW'(c_NIN - 1)) begin
                  r_state <= S_L1;
                  r_k     <= '0;
                  r_node  <= '0;
                  r_base  <= '0;
               end
            end
            S_L1, S_L2, S_OUT: begin
               if (r_k < w_fan_in) begin
                  r_acc <= w_sum;
                  r_k   <= r_k + 1'b1;
               end else begin
                  r_k <= '0;
                  if (r_node == w_last_node) begin
                     r_node  <= '0;
                     r_base  <= '0;
                     r_state <= w_next;
                  end else begin
                     r_node <= r_node + 1'b1;
                     r_base <= w_b_addr + 1'b1;
                  end
               end
            end
            S_MAX: begin
               // Strict greater-than so ties keep the lower index
               if (r_k == '0) r_best <= r_q[0];
               else if (fp_gt(r_q[r_k[c_QW-1:0]], r_best)) r_best <= r_q[r_k[c_QW-1:0]];
               if (r_k == c_KW'(c_NOUT - 1)) begin
                  r_k     <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            S_DONE: begin
               o_q_max       <= r_best;
               o_q_max_valid <= 1'b1;
               r_state       <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dqn_target_net.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_dqn_target_net : directed scoreboard bench for dqn_target_net          |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_dqn_target_net;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_data_valid;
   logic [4:0]  i_data_addr;
   logic [31:0] i_data;
   logic        i_weight_valid;
   logic        i_rw_weight_select;
   logic [1:0]  i_weight_layer;
   logic [10:0] i_weight_addr;
   logic [31:0] i_weight;
   logic        o_weight_valid;
   logic [1:0]  o_weight_layer;
   logic [10:0] o_weight_addr;
   logic [31:0] o_weight;
   logic        o_q_max_valid;
   logic [31:0] o_q_max;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] sb [$];

   always #5 clk = ~clk;

   dqn_target_net dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_data_valid       (i_data_valid),
      .i_data_addr        (i_data_addr),
      .i_data             (i_data),
      .i_weight_valid     (i_weight_valid),
      .i_rw_weight_select (i_rw_weight_select),
      .i_weight_layer     (i_weight_layer),
      .i_weight_addr      (i_weight_addr),
      .i_weight           (i_weight),
      .o_weight_valid     (o_weight_valid),
      .o_weight_layer     (o_weight_layer),
      .o_weight_addr      (o_weight_addr),
      .o_weight           (o_weight),
      .o_q_max_valid      (o_q_max_valid),
      .o_q_max            (o_q_max)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write_w(input logic [1:0] layer, input int addr, input logic [31:0] val);
      i_weight_valid     = 1'b1;
      i_rw_weight_select = 1'b0;
      i_weight_layer     = layer;
      i_weight_addr      = 11'(addr);
      i_weight           = val;
      @(posedge clk); #1;
      i_weight_valid     = 1'b0;
   endtask

   task automatic write_data(input logic [4:0] addr, input logic [31:0] val);
      i_data_valid = 1'b1;
      i_data_addr  = addr;
      i_data       = val;
      @(posedge clk); #1;
      i_data_valid = 1'b0;
   endtask

   task automatic read_req(input logic [1:0] layer, input int addr);
      i_weight_valid     = 1'b1;
      i_rw_weight_select = 1'b1;
      i_weight_layer     = layer;
      i_weight_addr      = 11'(addr);
      @(posedge clk); #1;
      i_weight_valid     = 1'b0;
      i_rw_weight_select = 1'b0;
   endtask

   // Optionally writes input 0, then starts with input 1; optionally pokes the DUT while busy
   task automatic run_pass(input string tag, input bit wr_x0, input logic [31:0] x0,
                           input logic [31:0] x1, input bit disturb, input logic [31:0] exp);
      int          cnt;
      bit          got;
      logic [31:0] exp_v;
      sb.push_back(exp);
      if (wr_x0) write_data(5'd0, x0);
      i_data_valid = 1'b1;
      i_data_addr  = 5'd1;
      i_data       = x1;
      @(posedge clk); #1;
      i_data_valid = 1'b0;
      cnt = 0;
      got = 1'b0;
      while (cnt < 1400 && !got) begin
         if (disturb && cnt == 5) begin
            i_data_valid       = 1'b1;
            i_data_addr        = 5'd0;
            i_data             = 32'hBFC00000;
            i_weight_valid     = 1'b1;
            i_rw_weight_select = 1'b0;
            i_weight_layer     = 2'b11;
            i_weight_addr      = 11'd65;
            i_weight           = 32'h40800000;
         end
         if (disturb && cnt == 6) begin
            i_data_valid   = 1'b1;
            i_data_addr    = 5'd1;
            i_data         = 32'h0;
            i_weight_valid = 1'b0;
         end
         if (disturb && cnt == 7) i_data_valid = 1'b0;
         @(posedge clk); #1;
         cnt++;
         if (o_q_max_valid) got = 1'b1;
      end
      exp_v = sb.pop_front();
      if (!got) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check({tag, "_latency"}, 32'(cnt), 32'd1255);
         check({tag, "_qmax"}, o_q_max, exp_v);
         @(posedge clk); #1;
         check({tag, "_pulse"}, 32'(o_q_max_valid), 32'd0);
         check({tag, "_hold"}, o_q_max, exp_v);
      end
   endtask

   initial begin
      rst_n              = 1'b0;
      i_data_valid       = 1'b0;
      i_data_addr        = '0;
      i_data             = '0;
      i_weight_valid     = 1'b0;
      i_rw_weight_select = 1'b0;
      i_weight_layer     = '0;
      i_weight_addr      = '0;
      i_weight           = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_qvalid", 32'(o_q_max_valid), 32'd0);
      check("rst_qmax", o_q_max, 32'd0);
      check("rst_wvalid", 32'(o_weight_valid), 32'd0);
      check("rst_weight", o_weight, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_qvalid", 32'(o_q_max_valid), 32'd0);
      check("post_rst_wvalid", 32'(o_weight_valid), 32'd0);

      for (int a = 0; a < 96; a++)   write_w(2'b01, a, 32'h0);
      for (int a = 0; a < 1056; a++) write_w(2'b10, a, 32'h0);
      for (int a = 0; a < 99; a++)   write_w(2'b11, a, 32'h0);

      // Output biases 0, 1.0, 2.0 with all other weights zero
      write_w(2'b11, 65, 32'h3F800000);
      write_w(2'b11, 98, 32'h40000000);
      run_pass("bias_max", 1'b1, 32'hBFC00000, 32'h3FA00000, 1'b0, 32'h40000000);

      rst_n = 1'b0;
      #2;
      check("midrst_qmax", o_q_max, 32'd0);
      check("midrst_qvalid", 32'(o_q_max_valid), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Chain input 0 through h1[0] -> every h2 node -> q0
      write_w(2'b11, 65, 32'h0);
      write_w(2'b11, 98, 32'h0);
      write_w(2'b01, 0, 32'h3F800000);
      for (int j = 0; j < 32; j++) write_w(2'b10, j*33, 32'h3F800000);
      write_w(2'b11, 0, 32'h3F800000);
      run_pass("leaky_neg", 1'b1, 32'hBFC00000, 32'h0, 1'b0, 32'h00000000);
      run_pass("leaky_pos", 1'b1, 32'h3FC00000, 32'h0, 1'b0, 32'h3FC00000);

      run_pass("busy", 1'b1, 32'h3FC00000, 32'h0, 1'b1, 32'h3FC00000);
      run_pass("after_busy", 1'b0, 32'h0, 32'h0, 1'b0, 32'h3FC00000);

      write_w(2'b10, 1055, 32'h12345678);
      read_req(2'b10, 1055);
`ifdef TARGET_NET_READBACK_EN
      check("rd_valid", 32'(o_weight_valid), 32'd1);
      check("rd_layer", 32'(o_weight_layer), 32'd2);
      check("rd_addr", 32'(o_weight_addr), 32'd1055);
      check("rd_data", o_weight, 32'h12345678);
      @(posedge clk); #1;
      check("rd_pulse", 32'(o_weight_valid), 32'd0);
      read_req(2'b00, 5);
      check("rd_layer0_ignored", 32'(o_weight_valid), 32'd0);
      read_req(2'b01, 96);
      check("rd_range_ignored", 32'(o_weight_valid), 32'd0);
`else
      check("rd_disabled_valid", 32'(o_weight_valid), 32'd0);
      check("rd_disabled_data", o_weight, 32'd0);
`endif
      write_w(2'b10, 1055, 32'h0);

      // All three outputs equal 1.0
      write_w(2'b11, 0, 32'h0);
      write_w(2'b11, 32, 32'h3F800000);
      write_w(2'b11, 65, 32'h3F800000);
      write_w(2'b11, 98, 32'h3F800000);
      run_pass("tie", 1'b1, 32'h3FC00000, 32'h0, 1'b0, 32'h3F800000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dqn_target_net.md
# dqn_target_net

Fixed-topology target Q-network for the DQN accelerator, in IEEE-754 single precision. The network is 2 inputs, 32 leaky-ReLU hidden nodes, 32 leaky-ReLU hidden nodes, and 3 linear outputs. Weights are loaded or read back through a layer-addressed port. Writing the last input starts a serial multiply-accumulate pass, and the block reports the maximum Q value. It sits beside the main network and supplies max Q(s′,a′) to the TD-target computation.

## Interface
Parameters:
- DATA_WIDTH, 32: word width, IEEE-754 single.
- LAYER_WIDTH, 2: width of the layer selector.
- NUMBER_OF_INPUT_NODE, 2: number of inputs.
- NUMBER_OF_HIDDEN_NODE_LAYER_1, 32: nodes in hidden layer 1.
- NUMBER_OF_HIDDEN_NODE_LAYER_2, 32: nodes in hidden layer 2.
- NUMBER_OF_OUTPUT_NODE, 3: number of Q outputs.
- ALPHA, 32'h3DCCCCCD (0.1): leaky-ReLU negative slope.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - rst_n  in  1  asynchronous active-low reset.
- Input data:
  - i_data_valid  in  1  input-word strobe.
  - i_data_addr  in  $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1)  input index.
  - i_data  in  32  input value.
- Weight access:
  - i_weight_valid  in  1  weight-access strobe.
  - i_rw_weight_select  in  1  0 = write, 1 = read.
  - i_weight_layer  in  2  01 = hidden 1, 10 = hidden 2, 11 = output; 00 = none.
  - i_weight_addr  in  11  word address within the layer.
  - i_weight  in  32  write data.
  - o_weight_valid  out  1  read-data strobe.
  - o_weight_layer  out  2  echoed layer.
  - o_weight_addr  out  11  echoed address.
  - o_weight  out  32  read data.
- Result:
  - o_q_max_valid  out  1  one-cycle result strobe.
  - o_q_max  out  32  maximum output Q.

## Operation
- **Weight memories:** three RAMs, one per layer.
  - Address = node*(fan_in+1)+k for input k < fan_in.
  - Address node*(fan_in+1)+fan_in holds that node's bias.
  - Sizes: 96 words (hidden 1), 1056 words (hidden 2), 99 words (output).
- **Weight write:** a write occurs when i_weight_valid=1, rw=0 and layer≠00, with the address in range.
- **Weight read:** a read (rw=1) returns the addressed word with layer and address echoed.
- **Ignored accesses:** layer 00 and out-of-range addresses are ignored; a read returns nothing.
- **Input data:** i_data_valid writes input register i_data_addr. Addresses ≥ NUMBER_OF_INPUT_NODE are ignored.
- **Start:** writing address NUMBER_OF_INPUT_NODE-1 while IDLE starts a pass.
- **While BUSY:** data writes and weight accesses are ignored.
- **FSM:** IDLE → L1 → L2 → OUT → MAX → DONE → IDLE.
- **Per node:** the accumulator is loaded with the bias, then one acc += w*x is performed per cycle in input order. There is one extra cycle for activation and writeback.
- **Activation:**
  - Hidden layers: y = x if the sign bit is 0, else ALPHA*x.
  - Output layer: linear.
- **MAX:** scans the 3 outputs using floating-point compare (sign, then magnitude). Ties keep the lower index.
- **Special values:** NaN and Inf propagate per the FP units; no special handling.
- **Arithmetic:** combinational FP32 multiply and add with round-to-nearest-even. Denormals are flushed to zero.

## Timing
- **Reset:** all outputs are 0, the FSM is IDLE and the input registers are 0. RAM contents are not reset.
- **Weight read latency:** 1 cycle. o_weight_valid is asserted the cycle after the accepted request, for 1 cycle.
- **Write latency:** a write is visible to a read or a pass starting the next cycle.
- **Pass latency:** o_q_max_valid rises exactly 1255 cycles after the starting data write. This is 96+1056+99 MAC/writeback cycles, plus 3 MAX, plus 1 DONE.
- **Result hold:** o_q_max_valid is high for 1 cycle. o_q_max holds its value until the next result.
- **Simultaneous events:** a data write and a weight access in the same IDLE cycle are both accepted.
- **Reset mid-pass:** aborts the pass to IDLE with no valid output.

## Configuration
- **TARGET_NET_READBACK_EN defined:** weight read (rw=1) is implemented as above.
- **TARGET_NET_READBACK_EN undefined:**
  - Read requests are ignored.
  - o_weight_valid, o_weight_layer, o_weight_addr and o_weight are tied 0.
  - RAMs may be write-only.

## Test plan
- **Reset defaults:** assert rst_n=0 mid-idle → all outputs 0; release → no spurious strobes.
- **Output bias selects max:** all weights 0; output biases 0, 3F800000, 40000000; write inputs BFC00000, 3FA00000 → one o_q_max_valid after 1255 cycles with o_q_max=40000000.
- **Leaky ReLU:**
  - Hidden-1 bias 0, weight0=3F800000 (other hidden-1 weights 0); every hidden-2 node copies hidden-1 node 0 via weight 3F800000 (other hidden-2 weights and biases 0).
  - Output node 0 weight to hidden-2 node 0 = 3F800000 (other output weights and biases 0).
  - Input0=BFC00000 → q0 = 0.01*(-1.5) = BC75C28F, q1=q2=0; q_max=00000000.
  - Flip input0 to 3FC00000 → q_max=3FC00000.
- **Readback:** write layer 10 addr 1055 = 12345678, then read it → next cycle o_weight_valid=1, layer 10, addr 1055, o_weight=12345678.
- **Busy lockout:** a data write during a pass → ignored, and the result equals an undisturbed run.
- **Tie-break:** all three outputs equal 3F800000 → q_max=3F800000.
